// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: shared ISA and control encodings for the 16-bit multi-cycle core.
//   - opcode and branch-condition encodings
//   - control FSM state encoding (also exported on the debug state port)
//   - PC-source and register-file write-source select encodings
//   - decode helpers used by the control unit
package cpu_isa_pkg;

  localparam logic [3:0] OpAluRi = 4'h0;
  localparam logic [3:0] OpAluRr = 4'h1;
  localparam logic [3:0] OpBr    = 4'h2;
  localparam logic [3:0] OpLi    = 4'h6;
  localparam logic [3:0] OpLdSt  = 4'h7;
  localparam logic [3:0] OpHalt  = 4'hF;

  localparam logic [2:0] CondAlways = 3'b000;
  localparam logic [2:0] CondZ      = 3'b001;
  localparam logic [2:0] CondNz     = 3'b010;
  localparam logic [2:0] CondN      = 3'b011;
  localparam logic [2:0] CondNn     = 3'b100;
  localparam logic [2:0] CondC      = 3'b101;
  localparam logic [2:0] CondNc     = 3'b110;
  localparam logic [2:0] CondNever  = 3'b111;

  localparam logic [1:0] PcSelInc = 2'b00;
  localparam logic [1:0] PcSelImm = 2'b01;

  localparam logic [1:0] WselAlu = 2'b00;
  localparam logic [1:0] WselImm = 2'b01;
  localparam logic [1:0] WselMem = 2'b10;

  typedef enum logic [3:0] {
    StIf   = 4'd0,
    StId   = 4'd1,
    StImm  = 4'd2,
    StEx   = 4'd3,
    StMem  = 4'd4,
    StWb   = 4'd5,
    StBr   = 4'd6,
    StHalt = 4'd7
  } state_t;

  // Opcodes followed by an immediate word.
  function automatic logic is_two_word(input logic [3:0] op);
    return (op == OpAluRi) || (op == OpBr) || (op == OpLi) || (op == OpLdSt);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return is_two_word(op) || (op == OpAluRr) || (op == OpHalt);
  endfunction

  function automatic logic cond_true(input logic [2:0] cond, input logic z, input logic n,
                                     input logic c);
    logic t;
    case (cond)
      CondAlways: t = 1'b1;
      CondZ:      t = z;
      CondNz:     t = ~z;
      CondN:      t = n;
      CondNn:     t = ~n;
      CondC:      t = c;
      CondNc:     t = ~c;
      default:    t = 1'b0;  // CondNever
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive stalled cycles of a memory access.
//   clk, reset  - clock, synchronous active-high reset
//   busy        - an access is being requested this cycle
//   mem_ready   - memory completes the access this cycle
//   timeout     - this is the WAIT_LIMIT-th consecutive stalled cycle (never when WAIT_LIMIT=0)
module mem_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic mem_ready,
  output logic timeout
);

  localparam int unsigned CntW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CntW-1:0] LastWait = CntW'(WAIT_LIMIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            waiting;

  // cnt_q holds the number of earlier stalled cycles, so the limit cycle itself times out.
  always_comb begin
    waiting = busy & ~mem_ready;
    timeout = (WAIT_LIMIT != 0) && waiting && (cnt_q == LastWait);
    cnt_d   = (waiting && !timeout) ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control unit of the 16-bit, 8-register core.
//   Inputs : clk, reset (sync, active-high), ir_opcode/ir_cond/ir_st (decoded IR fields),
//            flag_z/n/c (registered flags), mem_ready (memory access completes).
//   Outputs: datapath strobes/selects (pc_we, pc_sel, ir_we, imm_we, mem_re, mem_we,
//            mem_addr_sel, alu_src_b, flag_we, rf_we, rf_wsel), status (halted, bus_err,
//            illegal), retired_cnt and the debug state.
module mc_control_fsm
  import cpu_isa_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ir_opcode,
  input  logic [2:0]       ir_cond,
  input  logic             ir_st,
  input  logic             flag_z,
  input  logic             flag_n,
  input  logic             flag_c,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             ir_we,
  output logic             imm_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             alu_src_b,
  output logic             flag_we,
  output logic             rf_we,
  output logic [1:0]       rf_wsel,
  output logic             halted,
  output logic             bus_err,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [3:0]       state
);

  state_t           state_q, state_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic             busy, timeout, retire, uses_imm;

  assign busy     = (state_q == StIf) || (state_q == StImm) || (state_q == StMem);
  assign uses_imm = (ir_opcode == OpAluRi) || (ir_opcode == OpLdSt);

  mem_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  // Next state, sticky bus error and retire point.
  always_comb begin
    state_d   = state_q;
    bus_err_d = bus_err_q;
    retire    = 1'b0;
    case (state_q)
      StIf: if (mem_ready) state_d = StId;
      StId: begin
        if (is_two_word(ir_opcode))     state_d = StImm;
        else if (ir_opcode == OpAluRr)  state_d = StEx;
        else if (ir_opcode == OpHalt)   state_d = StHalt;
        else                            state_d = StIf;
      end
      StImm: begin
        if (mem_ready) begin
          if (ir_opcode == OpBr)      state_d = StBr;
          else if (ir_opcode == OpLi) state_d = StWb;
          else                        state_d = StEx;
        end
      end
      StEx: state_d = (ir_opcode == OpLdSt) ? StMem : StWb;
      StMem: begin
        if (mem_ready) begin
          state_d = ir_st ? StIf : StWb;
          retire  = ir_st;
        end
      end
      StWb, StBr: begin
        state_d = StIf;
        retire  = 1'b1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIf;
    endcase
    // Timeout only fires while mem_ready=0, so it never races a completing access.
    if (timeout) begin
      state_d   = StHalt;
      bus_err_d = 1'b1;
    end
    retired_cnt_d = retire ? retired_cnt_q + 1'b1 : retired_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIf;
      bus_err_q     <= 1'b0;
      retired_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      bus_err_q     <= bus_err_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  // Moore decode of state_q; only the memory strobes look at mem_ready. Forced idle in reset.
  always_comb begin
    pc_we        = 1'b0;
    pc_sel       = PcSelInc;
    ir_we        = 1'b0;
    imm_we       = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_src_b    = 1'b0;
    flag_we      = 1'b0;
    rf_we        = 1'b0;
    rf_wsel      = WselAlu;
    illegal      = 1'b0;
    if (!reset) begin
      case (state_q)
        StIf: begin
          mem_re = 1'b1;
          ir_we  = mem_ready;
          pc_we  = mem_ready;
        end
        StId: illegal = ~is_legal(ir_opcode);
        StImm: begin
          mem_re = 1'b1;
          imm_we = mem_ready;
          pc_we  = mem_ready;
        end
        StEx: begin
          alu_src_b = uses_imm;
          flag_we   = (ir_opcode == OpAluRi) || (ir_opcode == OpAluRr);
        end
        StMem: begin
          // The ALU keeps producing rs+imm as the address for the whole access.
          alu_src_b    = 1'b1;
          mem_addr_sel = 1'b1;
          mem_re       = ~ir_st;
          mem_we       = ir_st;
        end
        StWb: begin
          alu_src_b = uses_imm;
          rf_we     = 1'b1;
          if (ir_opcode == OpLi)        rf_wsel = WselImm;
          else if (ir_opcode == OpLdSt) rf_wsel = WselMem;
          else                          rf_wsel = WselAlu;
        end
        StBr: begin
          if (cond_true(ir_cond, flag_z, flag_n, flag_c)) begin
            pc_we  = 1'b1;
            pc_sel = PcSelImm;
          end
        end
        default: ;
      endcase
    end
  end

  assign halted      = (state_q == StHalt);
  assign bus_err     = bus_err_q;
  assign retired_cnt = retired_cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed and randomized instruction sequences for mc_control_fsm.
// A per-instruction phase model predicts state, strobes and retired count for every cycle.
module tb_mc_control_fsm;
  import cpu_isa_pkg::*;

  localparam int unsigned WaitLimit = 15;
  localparam int unsigned CntW      = 4;  // small so the retire counter wraps

  // Packed view of the outputs: {pc_we, pc_sel, ir_we, imm_we, mem_re, mem_we, mem_addr_sel,
  // alu_src_b, flag_we, rf_we, rf_wsel, halted, bus_err, illegal}
  localparam logic [15:0] M_PCWE     = 16'h8000;
  localparam logic [15:0] M_PCSEL    = 16'h6000;
  localparam logic [15:0] M_PCSELIMM = 16'h2000;
  localparam logic [15:0] M_IRWE     = 16'h1000;
  localparam logic [15:0] M_IMMWE    = 16'h0800;
  localparam logic [15:0] M_MRE      = 16'h0400;
  localparam logic [15:0] M_MWE      = 16'h0200;
  localparam logic [15:0] M_MAS      = 16'h0100;
  localparam logic [15:0] M_ASB      = 16'h0080;
  localparam logic [15:0] M_FWE      = 16'h0040;
  localparam logic [15:0] M_RFWE     = 16'h0020;
  localparam logic [15:0] M_WSEL     = 16'h0018;
  localparam logic [15:0] M_WSELIMM  = 16'h0008;
  localparam logic [15:0] M_WSELMEM  = 16'h0010;
  localparam logic [15:0] M_HALT     = 16'h0004;
  localparam logic [15:0] M_BERR     = 16'h0002;
  localparam logic [15:0] M_ILL      = 16'h0001;
  localparam logic [15:0] M_STROBES  = 16'h9E61;

  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] ir_opcode = '0;
  logic [2:0] ir_cond = '0;
  logic ir_st = 1'b0, flag_z = 1'b0, flag_n = 1'b0, flag_c = 1'b0, mem_ready = 1'b0;
  logic pc_we, ir_we, imm_we, mem_re, mem_we, mem_addr_sel, alu_src_b, flag_we, rf_we;
  logic halted, bus_err, illegal;
  logic [1:0] pc_sel, rf_wsel;
  logic [CntW-1:0] retired_cnt;
  logic [3:0] state;
  logic [15:0] obs;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int exp_cnt = 0;
  bit model_berr = 1'b0;
  string ctx = "init";

  mc_control_fsm #(
    .WAIT_LIMIT(WaitLimit),
    .CNT_W     (CntW)
  ) dut (
    .clk(clk), .reset(reset), .ir_opcode(ir_opcode), .ir_cond(ir_cond), .ir_st(ir_st),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we), .imm_we(imm_we), .mem_re(mem_re),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .alu_src_b(alu_src_b), .flag_we(flag_we),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .halted(halted), .bus_err(bus_err), .illegal(illegal),
    .retired_cnt(retired_cnt), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {pc_we, pc_sel, ir_we, imm_we, mem_re, mem_we, mem_addr_sel, alu_src_b,
                flag_we, rf_we, rf_wsel, halted, bus_err, illegal};

  function automatic bit rr();
    return bit'($urandom_range(0, 1));
  endfunction

  // Branch condition table: 000 always, 001 Z, 010 !Z, 011 N, 100 !N, 101 C, 110 !C, 111 never.
  function automatic bit br_taken(input logic [2:0] cond, input bit z, input bit n, input bit c);
    bit t;
    case (cond)
      3'd0: t = 1'b1;
      3'd1: t = z;
      3'd2: t = !z;
      3'd3: t = n;
      3'd4: t = !n;
      3'd5: t = c;
      3'd6: t = !c;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", ctx, tag, o, e);
    end
  endtask

  // One clock cycle: drive mem_ready, check outputs mid-cycle, advance the retire model.
  task automatic step(input state_t st, input bit rdy, input logic [15:0] e, input bit retire);
    logic [15:0] ev, mask;
    ev = e;
    if (model_berr) ev |= M_BERR;
    if (st == StHalt) ev |= M_HALT;
    mask = 16'hFFFF;
    if (st != StEx) mask &= ~M_ASB;
    if (st != StWb) mask &= ~M_WSEL;
    if ((ev & M_PCWE) == 16'h0) mask &= ~M_PCSEL;
    mem_ready = rdy;
    @(negedge clk);
    chk("state", 32'(state), 32'(st));
    chk("outputs", 32'(obs & mask), 32'(ev & mask));
    chk("retired", 32'(retired_cnt), 32'(exp_cnt));
    if (retire) exp_cnt = (exp_cnt + 1) % (1 << CntW);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      mem_ready = rr();
      @(negedge clk);
      chk("reset_strobes", 32'(obs & M_STROBES), 32'h0);
      @(posedge clk);
      #1;
    end
    reset      = 1'b0;
    exp_cnt    = 0;
    model_berr = 1'b0;
  endtask

  // Full instruction from IF to its last phase, with the given stall counts per access.
  task automatic run_instr(input logic [3:0] op, input logic [11:0] ir, input bit z,
                           input bit n, input bit c, input int wif, input int wimm,
                           input int wmem);
    bit two_word;
    logic [15:0] e_mem;
    ir_opcode = op;
    ir_cond   = ir[11:9];
    ir_st     = ir[11];
    flag_z    = z;
    flag_n    = n;
    flag_c    = c;
    two_word  = (op == 4'h0) || (op == 4'h2) || (op == 4'h6) || (op == 4'h7);
    for (int i = 0; i < wif; i++) step(StIf, 1'b0, M_MRE, 1'b0);
    step(StIf, 1'b1, M_MRE | M_IRWE | M_PCWE, 1'b0);
    if (!two_word && op != 4'h1 && op != 4'hF) begin
      step(StId, rr(), M_ILL, 1'b0);
      return;
    end
    step(StId, rr(), 16'h0, 1'b0);
    if (op == 4'hF) begin
      repeat (3) step(StHalt, rr(), 16'h0, 1'b0);
      return;
    end
    if (two_word) begin
      for (int i = 0; i < wimm; i++) step(StImm, 1'b0, M_MRE, 1'b0);
      step(StImm, 1'b1, M_MRE | M_IMMWE | M_PCWE, 1'b0);
    end
    case (op)
      4'h2: step(StBr, rr(), br_taken(ir[11:9], z, n, c) ? (M_PCWE | M_PCSELIMM) : 16'h0,
                 1'b1);
      4'h6: step(StWb, rr(), M_RFWE | M_WSELIMM, 1'b1);
      4'h0: begin
        step(StEx, rr(), M_ASB | M_FWE, 1'b0);
        step(StWb, rr(), M_RFWE, 1'b1);
      end
      4'h1: begin
        step(StEx, rr(), M_FWE, 1'b0);
        step(StWb, rr(), M_RFWE, 1'b1);
      end
      default: begin  // LD/ST
        step(StEx, rr(), M_ASB, 1'b0);
        e_mem = M_MAS | (ir[11] ? M_MWE : M_MRE);
        for (int i = 0; i < wmem; i++) step(StMem, 1'b0, e_mem, 1'b0);
        step(StMem, 1'b1, e_mem, ir[11]);
        if (!ir[11]) step(StWb, rr(), M_RFWE | M_WSELMEM, 1'b1);
      end
    endcase
  endtask

  initial begin
    logic [3:0] op;
    #1;
    ctx = "reset";
    do_reset(5);

    ctx = "alu_rr";
    run_instr(4'h1, 12'h000, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    ctx = "li_st";
    run_instr(4'h6, 12'h123, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    run_instr(4'h7, 12'h800, 1'b0, 1'b0, 1'b0, 0, 0, 3);
    ctx = "ld";
    run_instr(4'h7, 12'h000, 1'b0, 1'b0, 1'b0, 1, 2, 2);

    ctx = "br";
    run_instr(4'h2, 12'h200, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    run_instr(4'h2, 12'h200, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    run_instr(4'h2, 12'hE00, 1'b1, 1'b1, 1'b1, 0, 0, 0);
    run_instr(4'h2, 12'h000, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    ctx = "illegal";
    run_instr(4'h5, 12'h000, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    ctx = "random";
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 14));
      run_instr(op, 12'($urandom), rr(), rr(), rr(), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    ctx = "limit_ready";
    run_instr(4'h1, 12'h000, 1'b0, 1'b0, 1'b0, WaitLimit - 1, 0, 0);
    run_instr(4'h6, 12'h000, 1'b0, 1'b0, 1'b0, 0, WaitLimit - 1, 0);
    run_instr(4'h7, 12'h000, 1'b0, 1'b0, 1'b0, 0, 0, WaitLimit - 1);

    ctx = "timeout_if";
    ir_opcode = 4'h1;
    for (int i = 0; i < WaitLimit; i++) step(StIf, 1'b0, M_MRE, 1'b0);
    model_berr = 1'b1;
    repeat (3) step(StHalt, rr(), 16'h0, 1'b0);
    do_reset(2);

    ctx = "timeout_mem";
    ir_opcode = 4'h7;
    ir_cond   = 3'b000;
    ir_st     = 1'b0;
    step(StIf, 1'b1, M_MRE | M_IRWE | M_PCWE, 1'b0);
    step(StId, rr(), 16'h0, 1'b0);
    step(StImm, 1'b1, M_MRE | M_IMMWE | M_PCWE, 1'b0);
    step(StEx, rr(), M_ASB, 1'b0);
    for (int i = 0; i < WaitLimit; i++) step(StMem, 1'b0, M_MAS | M_MRE, 1'b0);
    model_berr = 1'b1;
    repeat (2) step(StHalt, rr(), 16'h0, 1'b0);
    do_reset(1);

    ctx = "halt";
    run_instr(4'h1, 12'h000, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    run_instr(4'hF, 12'h000, 1'b0, 1'b0, 1'b0, 1, 0, 0);
    do_reset(1);

    ctx = "reset_mid_mem";
    run_instr(4'h6, 12'h000, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    ir_opcode = 4'h7;
    ir_cond   = 3'b000;
    ir_st     = 1'b0;
    step(StIf, 1'b1, M_MRE | M_IRWE | M_PCWE, 1'b0);
    step(StId, rr(), 16'h0, 1'b0);
    step(StImm, 1'b1, M_MRE | M_IMMWE | M_PCWE, 1'b0);
    step(StEx, rr(), M_ASB, 1'b0);
    step(StMem, 1'b0, M_MAS | M_MRE, 1'b0);
    do_reset(1);
    run_instr(4'h0, 12'h000, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    step(StIf, 1'b0, M_MRE, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
